loss: RTL

Output-side terminal of the activation pipeline, facing the `sigmoid` block across its result/error channels. It accepts an 8-bit activation on the `res` channel and an 8-bit target on the `tgt` channel, then forms the signed Q8.8 error `tgt - res`. In training mode (`en=1`) it returns the error on the `err` channel, which feeds `sigmoid`'s error input. It also keeps saturating sample and misclassification counters for the host.

---
 rtl/loss.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/loss.sv
// ============================================================================
//  Module   : loss
//  Purpose  : Pairs activation/target samples, returns the saturated Q8.8 error
//             tgt - res in training mode, and counts samples and misclassifications.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module loss #(
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        res_stb,
    output logic        res_rdy,
    input  logic [7:0]  res_dat,
    input  logic        tgt_stb,
    output logic        tgt_rdy,
    input  logic [7:0]  tgt_dat,
    output logic        err_stb,
    input  logic        err_rdy,
    output logic [15:0] err_dat,
    output logic [15:0] cnt,
    output logic [15:0] mis
);

    localparam logic [0:0]  c_st_fill = 1'b0;
    localparam logic [0:0]  c_st_send = 1'b1;
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [0:0]  state_q,    state_d;
    logic        res_full_q, res_full_d;
    logic        tgt_full_q, tgt_full_d;
    logic [7:0]  res_q,      res_d;
    logic [7:0]  tgt_q,      tgt_d;
    logic [15:0] err_dat_q,  err_dat_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [15:0] mis_q,      mis_d;

    logic               w_res_take;
    logic               w_tgt_take;
    logic               w_slot_free;
    logic               w_complete;
    logic               w_emit;
    logic signed [8:0]  w_diff;
    logic signed [17:0] w_diff_ext;
    logic signed [17:0] w_shifted;
    logic [15:0]        w_err_sat;

    assign res_rdy     = rst & ~res_full_q;
    assign tgt_rdy     = tgt_full_q ? 1'b0 : rst;
    assign w_res_take  = res_stb & res_rdy;
    assign w_tgt_take  = tgt_stb & tgt_rdy;
    assign w_slot_free = (state_q == c_st_fill) | err_rdy;
    assign w_complete  = res_full_q & tgt_full_q & w_slot_free;
    assign w_emit      = w_complete & en;

    // Zero-extended operands give a 9-bit signed difference that is already Q8.8
    // once sign-extended; 18 bits hold the worst case shifted by 8 without wrap.
    always_comb begin
        w_diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, res_q});
        w_diff_ext = {{9{w_diff[8]}}, w_diff};
        w_shifted  = w_diff_ext <<< SHIFT;
        if (w_shifted > 18'sh07FFF) begin
            w_err_sat = 16'h7FFF;
        end else if (w_shifted < -18'sh08000) begin
            w_err_sat = 16'h8000;
        end else begin
            w_err_sat = w_shifted[15:0];
        end
    end

    always_comb begin
        res_full_d = res_full_q;
        tgt_full_d = tgt_full_q;
        res_d      = res_q;
        tgt_d      = tgt_q;
        if (w_complete) begin
            res_full_d = 1'b0;
            tgt_full_d = 1'b0;
        end
        if (w_res_take) begin
            res_full_d = 1'b1;
            res_d      = res_dat;
        end
        if (w_tgt_take) begin
            tgt_full_d = 1'b1;
            tgt_d      = tgt_dat;
        end
    end

    // A clear on a completion edge discards that pair's contribution.
    always_comb begin
        cnt_d = cnt_q;
        mis_d = mis_q;
        if (clr) begin
            cnt_d = 16'h0000;
            mis_d = 16'h0000;
        end else if (w_complete) begin
            if (cnt_q != c_cnt_max) begin
                cnt_d = cnt_q + 16'h0001;
            end
            if ((res_q[7] != tgt_q[7]) && (mis_q != c_cnt_max)) begin
                mis_d = mis_q + 16'h0001;
            end
        end
    end

    always_comb begin
        err_dat_d = err_dat_q;
        if (w_emit) begin
            err_dat_d = w_err_sat;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_fill: begin
                if (w_emit) begin
                    state_d = c_st_send;
                end
            end
            c_st_send: begin
                if (err_rdy && !w_emit) begin
                    state_d = c_st_fill;
                end
            end
            default: state_d = c_st_fill;
        endcase
    end

    always_comb begin
        err_stb = (state_q == c_st_send);
        err_dat = err_dat_q;
        cnt     = cnt_q;
        mis     = mis_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= c_st_fill;
            res_full_q <= 1'b0;
            tgt_full_q <= 1'b0;
            res_q      <= 8'h00;
            tgt_q      <= 8'h00;
            err_dat_q  <= 16'h0000;
            cnt_q      <= 16'h0000;
            mis_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            res_full_q <= res_full_d;
            tgt_full_q <= tgt_full_d;
            res_q      <= res_d;
            tgt_q      <= tgt_d;
            err_dat_q  <= err_dat_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
        end
    end

endmodule

`default_nettype wire
